// File: rtl/uart1_tx.sv
// UART1 serial transmitter: start bit, 8 data bits LSB first, 1 or 2 stop bits.
// Define UART1_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart1_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_sis,
    input  logic                 rst,
    input  logic                 start_bit,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 stop_bit,
    output logic                 tx1,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART1_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]           state_reg;
    logic [CW-1:0]        baud_cnt_reg;
    logic [IW-1:0]        bit_idx_reg;
    logic [DATA_BITS-1:0] data_shift_reg;
    logic                 stop2_reg;
    logic                 tx_reg;
    logic                 busy_reg;
    logic                 done_reg;
`ifdef UART1_PARITY_EN
    logic                 parity_reg;
`endif
    logic                 bit_end;

    assign bit_end = (baud_cnt_reg == BAUD_LAST);

    // The counter runs in every non-idle state, so each bit lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk_sis) begin
        if (rst) begin
            baud_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            baud_cnt_reg <= '0;
        end else if (bit_end) begin
            baud_cnt_reg <= '0;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
        end
    end

    // tx_reg is loaded at each bit boundary with the value of the bit that is about to start.
    always_ff @(posedge clk_sis) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            bit_idx_reg    <= '0;
            data_shift_reg <= '0;
            stop2_reg      <= 1'b0;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
`ifdef UART1_PARITY_EN
            parity_reg     <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_bit) begin
                        state_reg      <= ST_START;
                        data_shift_reg <= data_in;
                        stop2_reg      <= stop_bit;
                        bit_idx_reg    <= '0;
                        tx_reg         <= 1'b0;
                        busy_reg       <= 1'b1;
`ifdef UART1_PARITY_EN
                        parity_reg     <= ^data_in;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_reg      <= ST_DATA;
                        tx_reg         <= data_shift_reg[0];
                        data_shift_reg <= {1'b0, data_shift_reg[DATA_BITS-1:1]};
                        bit_idx_reg    <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_reg == IDX_LAST) begin
                            bit_idx_reg <= '0;
`ifdef UART1_PARITY_EN
                            state_reg   <= ST_PARITY;
                            tx_reg      <= parity_reg;
`else
                            state_reg   <= ST_STOP;
                            tx_reg      <= 1'b1;
`endif
                        end else begin
                            tx_reg         <= data_shift_reg[0];
                            data_shift_reg <= {1'b0, data_shift_reg[DATA_BITS-1:1]};
                            bit_idx_reg    <= bit_idx_reg + 1'b1;
                        end
                    end
                end
`ifdef UART1_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state_reg   <= ST_STOP;
                        tx_reg      <= 1'b1;
                        bit_idx_reg <= '0;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        // bit_idx_reg doubles as the stop-bit counter.
                        if (stop2_reg && (bit_idx_reg == IW'(0))) begin
                            bit_idx_reg <= IW'(1);
                        end else begin
                            state_reg   <= ST_IDLE;
                            busy_reg    <= 1'b0;
                            done_reg    <= 1'b1;
                            bit_idx_reg <= '0;
                        end
                        tx_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign tx1  = tx_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_uart1_tx.sv
// Self-checking bench for uart1_tx: compares the serial line cycle by cycle against a
// frame model built from the bit list (start, data LSB first, [parity], stop bits).
module tb_uart1_tx;

    localparam int CPB = 4;
`ifdef UART1_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk_sis = 1'b0;
    logic       rst = 1'b1;
    logic       start_bit = 1'b0;
    logic       stop_bit = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx1;
    logic       busy;
    logic       done;

    int compared = 0;
    int mismatched = 0;
    int frame_no = 0;

    always #5 clk_sis = ~clk_sis;

    uart1_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk_sis   (clk_sis),
        .rst       (rst),
        .start_bit (start_bit),
        .data_in   (data_in),
        .stop_bit  (stop_bit),
        .tx1       (tx1),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Number of bit slots in a frame.
    function automatic int frame_bits(input logic s2);
        return 1 + 8 + PAR + 1 + (s2 ? 1 : 0);
    endfunction

    // Line value in bit slot n of a frame carrying d.
    function automatic logic line_bit(input logic [7:0] d, input int n);
        int ones;
        if (n == 0) return 1'b0;
        if (n <= 8) return d[n-1];
        if (PAR == 1 && n == 9) begin
            ones = 0;
            for (int i = 0; i < 8; i++) ones += d[i];
            return (ones % 2) == 1;
        end
        return 1'b1;
    endfunction

    // Starts and fully checks one frame. Entered and left at a falling edge; on return the
    // done cycle has been checked and the next rising edge is the first IDLE edge.
    task automatic run_frame(input logic [7:0] d, input logic s2, input bit hold, input bit disturb);
        int cycles;
        data_in   = d;
        stop_bit  = s2;
        start_bit = 1'b1;
        cycles = frame_bits(s2) * CPB;
        @(negedge clk_sis);
        if (!hold) start_bit = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            chk("tx1_frame", tx1, line_bit(d, k / CPB));
            chk("busy_frame", busy, 1'b1);
            chk("done_early", done, 1'b0);
            if (disturb && k == 10) begin
                start_bit = 1'b1;
                data_in   = ~d;
                stop_bit  = ~s2;
            end
            if (disturb && k == 11) begin
                start_bit = 1'b0;
                data_in   = 8'($urandom);
            end
            @(negedge clk_sis);
        end
        chk("done_pulse", done, 1'b1);
        chk("busy_end", busy, 1'b0);
        chk("tx1_end", tx1, 1'b1);
        frame_no++;
        $display("frame %0d: data=%02h stop2=%0d hold=%0d disturb=%0d cycles=%0d",
                 frame_no, d, s2, hold, disturb, cycles);
    endtask

    task automatic expect_idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_sis);
            chk("tx1_idle", tx1, 1'b1);
            chk("busy_idle", busy, 1'b0);
            chk("done_idle", done, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic       rs;

        // Reset held for three edges, then a quiet line.
        rst = 1'b1;
        repeat (3) @(negedge clk_sis);
        chk("rst_tx1", tx1, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        expect_idle(50);

        // Directed frames.
        run_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        expect_idle(3);
        run_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        expect_idle(3);

        // Reset during data bit 3 of an 8'hFF frame.
        data_in   = 8'hFF;
        stop_bit  = 1'b0;
        start_bit = 1'b1;
        @(negedge clk_sis);
        start_bit = 1'b0;
        for (int k = 0; k < 4 * CPB + 1; k++) begin
            chk("tx1_pre_abort", tx1, line_bit(8'hFF, k / CPB));
            @(negedge clk_sis);
        end
        rst = 1'b1;
        @(negedge clk_sis);
        rst = 1'b0;
        chk("abort_tx1", tx1, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        $display("abort: frame 8'hFF reset during data bit 3");
        expect_idle(12 * CPB);
        run_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        expect_idle(2);

        // Reset and request on the same edge: reset wins.
        rst = 1'b1;
        start_bit = 1'b1;
        @(negedge clk_sis);
        rst = 1'b0;
        start_bit = 1'b0;
        chk("rst_wins_tx1", tx1, 1'b1);
        chk("rst_wins_busy", busy, 1'b0);
        expect_idle(5);

        // Back-to-back with start_bit held high: one idle cycle (the done cycle) between frames.
        run_frame(8'h01, 1'b0, 1'b1, 1'b0);
        run_frame(8'h01, 1'b0, 1'b1, 1'b0);
        run_frame(8'h01, 1'b1, 1'b0, 1'b0);
        expect_idle(4);

`ifdef UART1_PARITY_EN
        run_frame(8'h07, 1'b0, 1'b0, 1'b0);
        expect_idle(2);
        run_frame(8'h03, 1'b0, 1'b0, 1'b0);
        expect_idle(2);
`endif

        // Randomized frames with random gaps and occasional mid-frame disturbance.
        for (int f = 0; f < 8; f++) begin
            rd = 8'($urandom);
            rs = 1'($urandom);
            run_frame(rd, rs, 1'b0, (f % 3) == 0);
            expect_idle(int'($urandom_range(1, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart1_tx.md
Name: uart1_tx

Overview:
- Serial UART transmitter for the UART1 channel.
- Accepts a parallel byte plus a send request and emits a standard asynchronous frame on tx1: start bit, 8 data bits LSB first, then 1 or 2 stop bits.
- Bit timing comes from an internal baud divider on the single system clock.
- Sits between the system-side byte source and the serial line.

Parameters:
- CLKS_PER_BIT, 16, system clock cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this channel, and data_in width follows it.

Ports:
- clk_sis  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start_bit  input  1  send request; sampled only in IDLE.
- data_in  input  8  byte to transmit; captured when the request is accepted.
- stop_bit  input  1  stop-bit count select, captured with data_in: 0 = one stop bit, 1 = two stop bits.
- tx1  output  1  serial line; idle high; registered.
- busy  output  1  high while a frame is in progress, from START through the last STOP bit.
- done  output  1  one-cycle pulse in the cycle after the final stop bit completes.

Behaviour:
- Reset, synchronous: on a clk_sis edge with rst=1:
  - tx1=1, busy=0, done=0, state=IDLE.
  - Baud counter, bit index and shift register are cleared.
  - Reset mid-frame aborts the frame; tx1 is 1 after that edge and no done pulse is produced.
- States and transitions:
  - IDLE → START: on an edge with start_bit=1, latch data_in into the shift register and latch stop_bit.
  - START → DATA: after CLKS_PER_BIT cycles.
  - DATA → STOP: after 8 bit periods.
  - STOP → IDLE: after 1 or 2 bit periods, per the latched stop_bit.
- Output timing:
  - tx1 falls to 0 and busy rises on the edge that accepts the request, so both are visible in the next cycle.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Baud counter runs 0..CLKS_PER_BIT-1; the bit advances when it reaches CLKS_PER_BIT-1, then it wraps to 0.
- Line values per state:
  - START: tx1=0.
  - DATA: tx1 = data bit[i], i = 0..7, LSB first.
  - STOP: tx1=1.
- Frame length:
  - (1+8+1)×CLKS_PER_BIT cycles for one stop bit.
  - (1+8+2)×CLKS_PER_BIT cycles for two stop bits.
  - Plus one bit period when the parity feature is enabled.
- On leaving STOP: busy=0 and done=1 for exactly one cycle, in IDLE.
- start_bit during a frame (busy=1) is ignored, not queued.
- Changes to data_in and stop_bit after acceptance do not affect the frame in progress.
- Back-to-back: with start_bit held high, the next frame is accepted on the first IDLE edge. The line therefore stays high at least one cycle between frames, beyond the stop bit(s).
- rst and start_bit high on the same edge: rst wins.

Optional Feature:
- Macro UART1_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP, lasting one bit period.
  - tx1 = XOR of the 8 latched data bits (even parity).
  - Frame length grows by CLKS_PER_BIT cycles.
- When undefined: no parity state and no parity logic; DATA goes directly to STOP.

Test Plan:
- CLKS_PER_BIT=4, assert rst 3 cycles → tx1=1, busy=0, done=0; line stays 1 with start_bit=0 for 50 cycles.
- data_in=8'hA5, stop_bit=0, pulse start_bit 1 cycle → tx1 sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1; busy high 40 cycles; done pulses once right after.
- data_in=8'h3C, stop_bit=1 → two stop bits, busy high 44 cycles; a second start_bit pulse at cycle 10 is ignored and data_in changed mid-frame has no effect.
- Assert rst during data bit 3 of an 8'hFF frame → tx1=1, busy=0 after that edge; no done; a new request afterwards produces a full correct frame.
- Hold start_bit=1 with data_in=8'h01 → consecutive frames separated by exactly one idle-high cycle; done pulses once per frame.
- With UART1_PARITY_EN defined, send 8'h07 → parity bit 1 inserted after bit 7; send 8'h03 → parity bit 0; busy lasts 44 cycles with one stop bit.
